// File: rtl/mdio_master_gen.sv
`default_nettype none
// ============================================================================
//  Module   : mdio_master_gen
//  Brief    : MDIO (Cl.22/Cl.45) management master. Generates MDC from clk,
//             serialises an optional preamble plus a 32-bit frame MSB-first,
//             releases the bus from TA onwards on reads and captures the
//             PHY response and TA check bit.
//  Revision : 1.0 - initial release
// ============================================================================
module mdio_master_gen #(
    parameter int CLK_DIV = 4,   // clk cycles per MDC period (even, >= 2)
    parameter int PRE_LEN = 32,  // preamble ones before ST, 0 = suppressed
    parameter int CNT_W   = 8    // bit counter width, 2^CNT_W > PRE_LEN+32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdio_start,
    input  logic [31:0] t_data,
    input  logic        mdio_in,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic        busy,
    output logic        mdio_done,
    output logic        data_rdy,
    output logic [15:0] rd_data,
    output logic        ta_err
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    // Phase on which the edge that raises mdc occurs (sampling edge)
    localparam logic [DIV_W-1:0] DIV_SAMP = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = (PRE_LEN == 0) ? '0 : CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] FRM_LAST = CNT_W'(31);
    localparam logic [CNT_W-1:0] TA_BIT1  = CNT_W'(14);
    localparam logic [CNT_W-1:0] TA_BIT2  = CNT_W'(15);
    localparam logic [CNT_W-1:0] DAT_BIT0 = CNT_W'(16);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_FRAME = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [31:0]      frame;
    logic             is_rd;
    logic [15:0]      shift;
    logic             ta_cand;
    logic             bit_end;
    logic             samp_edge;

    assign bit_end   = (div_cnt == DIV_LAST);
    assign samp_edge = (div_cnt == DIV_SAMP);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and pad/status outputs derived from the current state
    always_comb begin
        state_nxt = state;
        mdc       = 1'b0;
        mdio_out  = 1'b1;
        mdio_oe   = 1'b0;
        busy      = 1'b0;
        mdio_done = 1'b0;
        data_rdy  = 1'b0;
        case (state)
            S_IDLE: begin
                if (mdio_start) begin
                    state_nxt = (PRE_LEN == 0) ? S_FRAME : S_PRE;
                end
            end
            S_PRE: begin
                busy    = 1'b1;
                mdio_oe = 1'b1;
                mdc     = (div_cnt >= DIV_HALF);
                if (bit_end && (bit_cnt == PRE_LAST)) begin
                    state_nxt = S_FRAME;
                end
            end
            S_FRAME: begin
                busy     = 1'b1;
                mdc      = (div_cnt >= DIV_HALF);
                // Bit index counts up from the MSB, so ~bit_cnt selects 31-bit_cnt
                mdio_out = frame[~bit_cnt[4:0]];
                // Reads hand the bus to the PHY from the first TA bit onwards
                mdio_oe  = !(is_rd && (bit_cnt >= TA_BIT1));
                if (bit_end && (bit_cnt == FRM_LAST)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                mdio_done = 1'b1;
                data_rdy  = is_rd;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Frame latch, MDC phase / bit counters, read capture and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            is_rd   <= 1'b0;
            shift   <= '0;
            ta_cand <= 1'b0;
            rd_data <= '0;
            ta_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mdio_start) begin
                        frame   <= t_data;
                        is_rd   <= t_data[29];
                        ta_err  <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                S_PRE, S_FRAME: begin
                    div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
                    if (bit_end) begin
                        // Counter restarts at each phase change (PRE->FRAME, FRAME->DONE)
                        bit_cnt <= (state_nxt != state) ? '0 : bit_cnt + 1'b1;
                    end
                    if ((state == S_FRAME) && is_rd && samp_edge) begin
                        if (bit_cnt == TA_BIT2) begin
                            ta_cand <= mdio_in;
                        end else if (bit_cnt >= DAT_BIT0) begin
                            shift <= {shift[14:0], mdio_in};
                        end
                    end
                    // Results become visible together with the done pulse
                    if ((state == S_FRAME) && (state_nxt == S_DONE) && is_rd) begin
                        rd_data <= shift;
                        ta_err  <= ta_cand;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdio_master_gen.sv
`default_nettype none
module tb_mdio_master_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    // Main instance: CLK_DIV=4, PRE_LEN=32
    logic        mdio_start = 1'b0;
    logic [31:0] t_data = '0;
    logic        mdio_in = 1'b1;
    logic        mdc, mdio_out, mdio_oe, busy, mdio_done, data_rdy, ta_err;
    logic [15:0] rd_data;

    // Second instance: CLK_DIV=2, PRE_LEN=0
    logic        start2 = 1'b0;
    logic [31:0] t_data2 = '0;
    logic        mdio_in2 = 1'b1;
    logic        mdc2, out2, oe2, busy2, done2, rdy2, ta2;
    logic [15:0] rd2;

    mdio_master_gen #(.CLK_DIV(4), .PRE_LEN(32), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .mdio_start(mdio_start), .t_data(t_data),
        .mdio_in(mdio_in), .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe),
        .busy(busy), .mdio_done(mdio_done), .data_rdy(data_rdy),
        .rd_data(rd_data), .ta_err(ta_err)
    );

    mdio_master_gen #(.CLK_DIV(2), .PRE_LEN(0), .CNT_W(8)) dut2 (
        .clk(clk), .reset(reset), .mdio_start(start2), .t_data(t_data2),
        .mdio_in(mdio_in2), .mdc(mdc2), .mdio_out(out2), .mdio_oe(oe2),
        .busy(busy2), .mdio_done(done2), .data_rdy(rdy2),
        .rd_data(rd2), .ta_err(ta2)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] last_rd = '0;

    // Checks every reset-value output of the main instance
    task automatic check_reset_vals(input string tag);
        n_cmp++;
        if ({mdc, mdio_out, mdio_oe, busy, mdio_done, data_rdy, ta_err} !== 7'b0100000) begin
            n_bad++;
            $display("FAIL %s_outs: got {mdc,out,oe,busy,done,rdy,ta_err}=%b want 0100000", tag,
                     {mdc, mdio_out, mdio_oe, busy, mdio_done, data_rdy, ta_err});
        end
        n_cmp++;
        if (rd_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL %s_rd_data: got %h want 0000", tag, rd_data);
        end
    endtask

    // Runs one frame on the main instance; call at a negedge with the DUT idle.
    // poke >= 0 re-asserts start with altered t_data at that cycle while busy.
    // b2b pulses start during the done cycle and expects it to be ignored.
    task automatic run_frame(input string tag, input logic [31:0] fr, input logic [15:0] phy,
                             input logic phy_on, input int poke, input logic b2b);
        logic        rd;
        int          first_done;
        int          k, ph, fb;
        logic        e_mdc, e_oe, e_out;
        logic [15:0] e_rd;
        rd = fr[29];
        first_done = -1;
        t_data = fr;
        mdio_start = 1'b1;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            k  = c / 4;
            ph = c % 4;
            fb = k - 32;
            mdio_start = (c == poke);
            t_data = (poke >= 0 && c >= poke) ? ~fr : fr;
            if (rd && fb == 15)      mdio_in = phy_on ? 1'b0 : 1'b1;
            else if (rd && fb >= 16) mdio_in = phy_on ? phy[31 - fb] : 1'b1;
            else                     mdio_in = 1'b1;
            if (c == 0) begin
                n_cmp++;
                if (busy !== 1'b1 || ta_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s_accept: got busy=%b ta_err=%b want busy=1 ta_err=0", tag, busy, ta_err);
                end
            end
            if (mdio_done === 1'b1 && first_done < 0) first_done = c;
            e_mdc = (ph >= 2);
            e_oe  = (k < 32) || !rd || (fb < 14);
            e_out = (k < 32) ? 1'b1 : fr[31 - fb];
            n_cmp++;
            if (mdc !== e_mdc || mdio_oe !== e_oe || (e_oe && mdio_out !== e_out)) begin
                n_bad++;
                $display("FAIL %s_bus c=%0d: got mdc=%b oe=%b out=%b want mdc=%b oe=%b out=%b",
                         tag, c, mdc, mdio_oe, mdio_out, e_mdc, e_oe, e_out);
            end
        end
        @(negedge clk);
        mdio_start = 1'b0;
        if (mdio_done === 1'b1 && first_done < 0) first_done = 256;
        n_cmp++;
        if (first_done + 1 !== 257) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d want 257", tag, first_done + 1);
        end
        e_rd = rd ? (phy_on ? phy : 16'hFFFF) : last_rd;
        n_cmp++;
        if (mdio_done !== 1'b1 || data_rdy !== rd || busy !== 1'b0 || mdio_oe !== 1'b0 || mdio_out !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done: got done=%b rdy=%b busy=%b oe=%b out=%b want 1 %b 0 0 1",
                     tag, mdio_done, data_rdy, busy, mdio_oe, mdio_out, rd);
        end
        n_cmp++;
        if (rd_data !== e_rd || ta_err !== (rd && !phy_on)) begin
            n_bad++;
            $display("FAIL %s_result: got rd_data=%h ta_err=%b want %h %b",
                     tag, rd_data, ta_err, e_rd, rd && !phy_on);
        end
        last_rd = e_rd;
        if (b2b) begin
            mdio_start = 1'b1;
            t_data = 32'h5000_0000;
        end
        @(negedge clk);
        mdio_start = 1'b0;
        n_cmp++;
        if (mdio_done !== 1'b0 || busy !== 1'b0 || data_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_post: got done=%b busy=%b rdy=%b want 0 0 0", tag, mdio_done, busy, data_rdy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_idle");
    endtask

    task automatic test_write();
        run_frame("write", 32'h51AA_BEEF, 16'h0000, 1'b1, -1, 1'b0);
    endtask

    task automatic test_read();
        run_frame("read", 32'h61AA_0000, 16'hCAFE, 1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_midframe();
        int seen;
        seen = 0;
        t_data = 32'h61AA_0000;
        mdio_start = 1'b1;
        @(negedge clk);
        mdio_start = 1'b0;
        repeat (150) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (mdio_done !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL midreset_quiet: got %0d cycles with done/busy want 0", seen);
        end
        last_rd = 16'h0000;
    endtask

    task automatic test_no_phy();
        run_frame("nophy", 32'h61AA_0000, 16'h0000, 1'b0, -1, 1'b0);
    endtask

    task automatic test_busy();
        run_frame("busy", 32'h51AA_BEEF, 16'h0000, 1'b1, 10, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_a", 32'h5123_4567, 16'h0000, 1'b1, -1, 1'b1);
        // Immediately a fresh read from the IDLE cycle, also clearing ta_err
        run_frame("b2b_b", 32'h6D55_0000, 16'h1234, 1'b1, -1, 1'b0);
    endtask

    task automatic test_pre0();
        logic [31:0] fr;
        int          first_done;
        fr = 32'h51AA_0001;
        first_done = -1;
        t_data2 = fr;
        start2 = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2 === 1'b1 && first_done < 0) first_done = c;
            n_cmp++;
            if (mdc2 !== logic'(c % 2) || oe2 !== 1'b1 || out2 !== fr[31 - c / 2] || busy2 !== 1'b1) begin
                n_bad++;
                $display("FAIL pre0_bus c=%0d: got mdc=%b oe=%b out=%b busy=%b want %b 1 %b 1",
                         c, mdc2, oe2, out2, busy2, logic'(c % 2), fr[31 - c / 2]);
            end
        end
        @(negedge clk);
        if (done2 === 1'b1 && first_done < 0) first_done = 64;
        n_cmp++;
        if (first_done + 1 !== 65) begin
            n_bad++;
            $display("FAIL pre0_latency: got %0d want 65", first_done + 1);
        end
        n_cmp++;
        if (rdy2 !== 1'b0 || busy2 !== 1'b0 || oe2 !== 1'b0) begin
            n_bad++;
            $display("FAIL pre0_done: got rdy=%b busy=%b oe=%b want 0 0 0", rdy2, busy2, oe2);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_reset_midframe();
        test_no_phy();
        test_busy();
        test_back_to_back();
        test_pre0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
